// File: rtl/st_video_analyzer.sv
// Measures hsync/vsync timing from the video core and classifies each frame as
// PAL50, NTSC60 or mono72, with a frame-aligned one-cycle vreset pulse.
module st_video_analyzer #(
    parameter int unsigned MONO_LEN_MIN  = 800,
    parameter int unsigned MONO_LEN_MAX  = 999,
    parameter int unsigned COL_LEN_MIN   = 1900,
    parameter int unsigned COL_LEN_MAX   = 2200,
    parameter int unsigned STABLE_FRAMES = 2
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        hsync_n,
    input  logic        vsync_n,
    output logic [1:0]  vmode,
    output logic        vreset,
    output logic        valid,
    output logic [11:0] line_len,
    output logic [9:0]  frame_lines
);

    localparam int unsigned LC_W   = 12;
    localparam int unsigned FC_W   = 10;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned MODE_W = 2;

    localparam logic [LC_W-1:0]  LC_MAX   = {LC_W{1'b1}};
    localparam logic [FC_W-1:0]  FC_MAX   = {FC_W{1'b1}};
    localparam logic [LC_W-1:0]  MONO_MIN = LC_W'(MONO_LEN_MIN);
    localparam logic [LC_W-1:0]  MONO_MAX = LC_W'(MONO_LEN_MAX);
    localparam logic [LC_W-1:0]  COL_MIN  = LC_W'(COL_LEN_MIN);
    localparam logic [LC_W-1:0]  COL_MAX  = LC_W'(COL_LEN_MAX);
    localparam logic [CNT_W-1:0] STABLE   = CNT_W'(STABLE_FRAMES);

    localparam logic [FC_W-1:0] MONO_LINES_MIN = FC_W'(480);
    localparam logic [FC_W-1:0] MONO_LINES_MAX = FC_W'(520);
    localparam logic [FC_W-1:0] PAL_LINES_MIN  = FC_W'(300);
    localparam logic [FC_W-1:0] PAL_LINES_MAX  = FC_W'(330);
    localparam logic [FC_W-1:0] NTSC_LINES_MIN = FC_W'(250);
    localparam logic [FC_W-1:0] NTSC_LINES_MAX = FC_W'(280);

    typedef enum logic [MODE_W-1:0] {
        MODE_PAL  = 2'b00,
        MODE_NTSC = 2'b01,
        MODE_MONO = 2'b10
    } mode_t;

    // FRAME_WAIT: no vsync seen since reset, so the current frame is partial
    typedef enum logic {
        FRAME_WAIT,
        FRAME_RUN
    } frame_state_t;

    frame_state_t     state, state_nx;
    logic             hs_q, vs_q;
    logic [LC_W-1:0]  lc, lc_nx;
    logic [FC_W-1:0]  fc, fc_nx;
    logic             armed, armed_nx;
    mode_t            cand, cand_nx;
    logic [CNT_W-1:0] count, count_nx;

    logic [MODE_W-1:0] vmode_nx;
    logic              vreset_nx;
    logic              valid_nx;
    logic [LC_W-1:0]   line_len_nx;
    logic [FC_W-1:0]   frame_lines_nx;

    logic  hs_fall, vs_fall;
    logic  len_mono, len_col;
    logic  cls_ok;
    mode_t cls;

    always_ff @(posedge clk32) begin
        if (reset) begin
            state       <= FRAME_WAIT;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            lc          <= '0;
            fc          <= '0;
            armed       <= 1'b0;
            cand        <= MODE_PAL;
            count       <= '0;
            vmode       <= '0;
            vreset      <= 1'b0;
            valid       <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            state       <= state_nx;
            hs_q        <= hsync_n;
            vs_q        <= vsync_n;
            lc          <= lc_nx;
            fc          <= fc_nx;
            armed       <= armed_nx;
            cand        <= cand_nx;
            count       <= count_nx;
            vmode       <= vmode_nx;
            vreset      <= vreset_nx;
            valid       <= valid_nx;
            line_len    <= line_len_nx;
            frame_lines <= frame_lines_nx;
        end
    end

    always_comb begin
        hs_fall        = hs_q & ~hsync_n;
        vs_fall        = vs_q & ~vsync_n;
        state_nx       = state;
        lc_nx          = lc;
        fc_nx          = fc;
        armed_nx       = armed;
        cand_nx        = cand;
        count_nx       = count;
        vmode_nx       = vmode;
        vreset_nx      = 1'b0;
        valid_nx       = valid;
        line_len_nx    = line_len;
        frame_lines_nx = frame_lines;

        // A saturated line counter means hsync has gone missing
        if (hs_fall) begin
            line_len_nx = (lc == LC_MAX) ? LC_MAX : lc + LC_W'(1);
            lc_nx       = '0;
        end else if (lc == LC_MAX) begin
            valid_nx = 1'b0;
            count_nx = '0;
        end else begin
            lc_nx = lc + LC_W'(1);
        end

        if (hs_fall && (fc != FC_MAX)) begin
            fc_nx = fc + FC_W'(1);
        end

        len_mono = (line_len_nx >= MONO_MIN) && (line_len_nx <= MONO_MAX);
        len_col  = (line_len_nx >= COL_MIN) && (line_len_nx <= COL_MAX);
        cls_ok   = 1'b1;
        cls      = MODE_PAL;
        if (len_mono && (fc >= MONO_LINES_MIN) && (fc <= MONO_LINES_MAX)) begin
            cls = MODE_MONO;
        end else if (len_col && (fc >= PAL_LINES_MIN) && (fc <= PAL_LINES_MAX)) begin
            cls = MODE_PAL;
        end else if (len_col && (fc >= NTSC_LINES_MIN) && (fc <= NTSC_LINES_MAX)) begin
            cls = MODE_NTSC;
        end else begin
            cls_ok = 1'b0;
        end

        // Frame close: an hsync in the same cycle belongs to the new frame
        if (vs_fall) begin
            frame_lines_nx = fc;
            fc_nx          = hs_fall ? FC_W'(1) : '0;
            state_nx       = FRAME_RUN;
            if (state == FRAME_RUN) begin
                if (!cls_ok) begin
                    valid_nx = 1'b0;
                    count_nx = '0;
                end else if (cls == cand) begin
                    count_nx = (count >= STABLE) ? STABLE : count + CNT_W'(1);
                end else begin
                    cand_nx  = cls;
                    count_nx = CNT_W'(1);
                end
                if (cls_ok && (count_nx == STABLE)) begin
                    vmode_nx = cls;
                    valid_nx = 1'b1;
                end
            end
        end

        if (hs_fall && (armed || vs_fall)) begin
            vreset_nx = 1'b1;
            armed_nx  = 1'b0;
        end else if (vs_fall) begin
            armed_nx = 1'b1;
        end
    end

endmodule

// File: tb/tb_st_video_analyzer.sv
// Bench for st_video_analyzer: generated sync streams checked against an
// event-level reference model plus fixed expectations for each scenario.
module tb_st_video_analyzer;

    localparam int MONO_MIN = 3;
    localparam int MONO_MAX = 5;
    localparam int COL_MIN  = 7;
    localparam int COL_MAX  = 10;
    localparam int STABLE   = 2;

    localparam int PAL_LEN    = 8;
    localparam int PAL_LINES  = 313;
    localparam int NTSC_LEN   = 7;
    localparam int NTSC_LINES = 263;
    localparam int MONO_LEN   = 4;
    localparam int MONO_LINES = 501;

    logic        clk32   = 1'b0;
    logic        reset   = 1'b1;
    logic        hsync_n = 1'b1;
    logic        vsync_n = 1'b1;
    logic [1:0]  vmode;
    logic        vreset;
    logic        valid;
    logic [11:0] line_len;
    logic [9:0]  frame_lines;

    st_video_analyzer #(
        .MONO_LEN_MIN (MONO_MIN),
        .MONO_LEN_MAX (MONO_MAX),
        .COL_LEN_MIN  (COL_MIN),
        .COL_LEN_MAX  (COL_MAX),
        .STABLE_FRAMES(STABLE)
    ) dut (
        .clk32      (clk32),
        .reset      (reset),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .vmode      (vmode),
        .vreset     (vreset),
        .valid      (valid),
        .line_len   (line_len),
        .frame_lines(frame_lines)
    );

    always #5 clk32 = ~clk32;

    int total = 0;
    int bad = 0;
    int cycles = 0;
    int cyc_diff = 0;
    int first_diff = -1;
    int pulses = 0;
    logic [25:0] snap = '0;

    // reference model state
    logic m_ph = 1'b1, m_pv = 1'b1;
    int   m_age = 0, m_lines = 0, m_cand = 0, m_streak = 0;
    logic m_open = 1'b0, m_armed = 1'b0;
    int   e_vmode = 0, e_len = 0, e_flines = 0, e_pulses = 0;
    logic e_vreset = 1'b0, e_valid = 1'b0;

    function automatic int class_of(input int len, input int lines);
        if (len >= MONO_MIN && len <= MONO_MAX && lines >= 480 && lines <= 520) return 2;
        if (len >= COL_MIN && len <= COL_MAX && lines >= 300 && lines <= 330) return 0;
        if (len >= COL_MIN && len <= COL_MAX && lines >= 250 && lines <= 280) return 1;
        return -1;
    endfunction

    task automatic model_step(input logic h, input logic v, input logic r);
        logic hf, vf;
        int   cls, s0;
        if (r) begin
            m_ph = 1'b1; m_pv = 1'b1; m_age = 0; m_lines = 0; m_open = 1'b0;
            m_armed = 1'b0; m_cand = 0; m_streak = 0;
            e_vmode = 0; e_vreset = 1'b0; e_valid = 1'b0; e_len = 0; e_flines = 0;
            return;
        end
        hf = m_ph & ~h;
        vf = m_pv & ~v;
        m_ph = h;
        m_pv = v;
        s0 = m_streak;
        m_age++;
        e_vreset = 1'b0;
        if (hf) begin
            e_len = (m_age > 4095) ? 4095 : m_age;
            m_age = 0;
        end else if (m_age > 4095) begin
            e_valid = 1'b0;
            m_streak = 0;
        end
        if (vf) begin
            e_flines = (m_lines > 1023) ? 1023 : m_lines;
            if (m_open) begin
                cls = class_of(e_len, m_lines);
                if (cls < 0) begin
                    e_valid = 1'b0;
                    m_streak = 0;
                end else begin
                    if (cls == m_cand) m_streak = (s0 + 1 > STABLE) ? STABLE : s0 + 1;
                    else begin
                        m_cand = cls;
                        m_streak = 1;
                    end
                    if (m_streak == STABLE) begin
                        e_vmode = cls;
                        e_valid = 1'b1;
                    end
                end
            end
            m_open = 1'b1;
            m_lines = hf ? 1 : 0;
        end else if (hf) begin
            m_lines++;
        end
        if (hf && (m_armed || vf)) begin
            e_vreset = 1'b1;
            m_armed = 1'b0;
            e_pulses++;
        end else if (vf) begin
            m_armed = 1'b1;
        end
    endtask

    task automatic tick(input logic h, input logic v, input logic r);
        @(negedge clk32);
        hsync_n = h;
        vsync_n = v;
        reset   = r;
        @(posedge clk32);
        #1;
        model_step(h, v, r);
        cycles++;
        if (vreset === 1'b1) pulses++;
        if (vmode !== 2'(e_vmode) || vreset !== e_vreset || valid !== e_valid ||
            line_len !== 12'(e_len) || frame_lines !== 10'(e_flines)) begin
            if (cyc_diff == 0) first_diff = cycles;
            cyc_diff++;
        end
    endtask

    // hsync low for one cycle at each line start; vsync low for vs_lines lines from voff
    task automatic frame(input int len, input int nlines, input int vs_lines,
                         input int voff, input int rst_line);
        int   pos;
        logic h, v, r;
        for (int i = 0; i < nlines; i++) begin
            for (int c = 0; c < len; c++) begin
                pos = i * len + c;
                h = (c != 0);
                v = !(pos >= voff && pos < voff + vs_lines * len);
                r = (i == rst_line && c == 3);
                tick(h, v, r);
                if (r) snap = {vmode, vreset, valid, line_len, frame_lines};
            end
        end
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        total++;
        if ({vmode, vreset, valid, line_len, frame_lines} !== 26'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h, required 0", {vmode, vreset, valid, line_len, frame_lines});
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++;
            $display("FAIL reset_model: %0d cycles differ (first at %0d), required 0", cyc_diff, first_diff);
        end
        cyc_diff = 0;
    endtask

    task automatic test_pal();
        int p0;
        p0 = pulses;
        frame(PAL_LEN, PAL_LINES, 3, PAL_LEN / 2, -1);
        frame(PAL_LEN, PAL_LINES, 3, PAL_LEN / 2, -1);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL pal_early_valid: got %b, required 0", valid);
        end
        frame(PAL_LEN, PAL_LINES, 3, PAL_LEN / 2, -1);
        total++;
        if (valid !== 1'b1 || vmode !== 2'b00) begin
            bad++;
            $display("FAIL pal_lock: valid=%b vmode=%b, required valid=1 vmode=00", valid, vmode);
        end
        frame(PAL_LEN, PAL_LINES, 3, PAL_LEN / 2, -1);
        total++;
        if (line_len !== 12'(PAL_LEN) || frame_lines !== 10'(PAL_LINES)) begin
            bad++;
            $display("FAIL pal_timing: line_len=%0d frame_lines=%0d, required %0d %0d",
                     line_len, frame_lines, PAL_LEN, PAL_LINES);
        end
        total++;
        if (pulses - p0 !== 4) begin
            bad++;
            $display("FAIL pal_vreset_count: got %0d, required 4", pulses - p0);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++;
            $display("FAIL pal_model: %0d cycles differ (first at %0d), required 0", cyc_diff, first_diff);
        end
        cyc_diff = 0;
    endtask

    task automatic test_ntsc();
        frame(NTSC_LEN, NTSC_LINES, 3, NTSC_LEN / 2, -1);
        frame(NTSC_LEN, NTSC_LINES, 3, NTSC_LEN / 2, -1);
        total++;
        if (vmode !== 2'b00 || valid !== 1'b1) begin
            bad++;
            $display("FAIL ntsc_hold: vmode=%b valid=%b, required 00 1", vmode, valid);
        end
        frame(NTSC_LEN, NTSC_LINES, 3, NTSC_LEN / 2, -1);
        total++;
        if (vmode !== 2'b01 || valid !== 1'b1) begin
            bad++;
            $display("FAIL ntsc_switch: vmode=%b valid=%b, required 01 1", vmode, valid);
        end
        total++;
        if (line_len !== 12'(NTSC_LEN) || frame_lines !== 10'(NTSC_LINES)) begin
            bad++;
            $display("FAIL ntsc_timing: line_len=%0d frame_lines=%0d, required %0d %0d",
                     line_len, frame_lines, NTSC_LEN, NTSC_LINES);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++;
            $display("FAIL ntsc_model: %0d cycles differ (first at %0d), required 0", cyc_diff, first_diff);
        end
        cyc_diff = 0;
    endtask

    task automatic test_mono();
        for (int k = 0; k < 3; k++) frame(MONO_LEN, MONO_LINES, 3, MONO_LEN / 2, -1);
        total++;
        if (vmode !== 2'b10 || valid !== 1'b1) begin
            bad++;
            $display("FAIL mono_lock: vmode=%b valid=%b, required 10 1", vmode, valid);
        end
        frame(MONO_LEN, 400, 3, MONO_LEN / 2, -1);
        frame(MONO_LEN, MONO_LINES, 3, MONO_LEN / 2, -1);
        total++;
        if (valid !== 1'b0 || vmode !== 2'b10 || frame_lines !== 10'd400) begin
            bad++;
            $display("FAIL mono_corrupt: valid=%b vmode=%b frame_lines=%0d, required 0 10 400",
                     valid, vmode, frame_lines);
        end
        frame(MONO_LEN, MONO_LINES, 3, MONO_LEN / 2, -1);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL mono_relock_early: valid=%b, required 0", valid);
        end
        frame(MONO_LEN, MONO_LINES, 3, MONO_LEN / 2, -1);
        total++;
        if (valid !== 1'b1 || vmode !== 2'b10) begin
            bad++;
            $display("FAIL mono_relock: valid=%b vmode=%b, required 1 10", valid, vmode);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++;
            $display("FAIL mono_model: %0d cycles differ (first at %0d), required 0", cyc_diff, first_diff);
        end
        cyc_diff = 0;
    endtask

    task automatic test_timeout();
        total++;
        if (valid !== 1'b1) begin
            bad++;
            $display("FAIL timeout_pre_valid: got %b, required 1", valid);
        end
        for (int k = 0; k < 5000; k++) tick(1'b1, 1'b1, 1'b0);
        total++;
        if (valid !== 1'b0 || vmode !== 2'b10) begin
            bad++;
            $display("FAIL timeout_drop: valid=%b vmode=%b, required 0 10", valid, vmode);
        end
        tick(1'b0, 1'b1, 1'b0);
        total++;
        if (line_len !== 12'd4095) begin
            bad++;
            $display("FAIL timeout_line_len: got %0d, required 4095", line_len);
        end
        for (int k = 1; k < PAL_LEN; k++) tick(1'b1, 1'b1, 1'b0);
        frame(PAL_LEN, PAL_LINES, 3, PAL_LEN / 2, -1);
        frame(PAL_LEN, PAL_LINES, 3, PAL_LEN / 2, -1);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_relock_early: valid=%b, required 0", valid);
        end
        frame(PAL_LEN, PAL_LINES, 3, PAL_LEN / 2, -1);
        total++;
        if (valid !== 1'b1 || vmode !== 2'b00) begin
            bad++;
            $display("FAIL timeout_relock: valid=%b vmode=%b, required 1 00", valid, vmode);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++;
            $display("FAIL timeout_model: %0d cycles differ (first at %0d), required 0", cyc_diff, first_diff);
        end
        cyc_diff = 0;
    endtask

    task automatic test_same_edge();
        int p0;
        p0 = pulses;
        frame(PAL_LEN, PAL_LINES, 3, 0, -1);
        total++;
        if (frame_lines !== 10'(PAL_LINES - 1)) begin
            bad++;
            $display("FAIL same_edge_close: frame_lines=%0d, required %0d", frame_lines, PAL_LINES - 1);
        end
        frame(PAL_LEN, PAL_LINES, 3, 0, -1);
        total++;
        if (frame_lines !== 10'(PAL_LINES) || pulses - p0 !== 2) begin
            bad++;
            $display("FAIL same_edge_open: frame_lines=%0d pulses=%0d, required %0d 2",
                     frame_lines, pulses - p0, PAL_LINES);
        end
        p0 = pulses;
        for (int c = 0; c < PAL_LEN; c++) tick(c != 0, !(c == 2 || c >= 4), 1'b0);
        total++;
        if (frame_lines !== 10'd0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL double_vs: frame_lines=%0d valid=%b, required 0 0", frame_lines, valid);
        end
        for (int c = 0; c < PAL_LEN; c++) tick(c != 0, 1'b0, 1'b0);
        for (int c = 0; c < PAL_LEN; c++) tick(c != 0, 1'b1, 1'b0);
        total++;
        if (pulses - p0 !== 1) begin
            bad++;
            $display("FAIL double_vs_pulse: got %0d pulses, required 1", pulses - p0);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++;
            $display("FAIL same_edge_model: %0d cycles differ (first at %0d), required 0", cyc_diff, first_diff);
        end
        cyc_diff = 0;
    endtask

    task automatic test_reset_mid();
        frame(PAL_LEN, PAL_LINES, 1, 1, 1);
        total++;
        if (snap !== 26'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got %h, required 0", snap);
        end
        frame(PAL_LEN, PAL_LINES, 3, PAL_LEN / 2, -1);
        frame(PAL_LEN, PAL_LINES, 3, PAL_LEN / 2, -1);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_first_frame: valid=%b, required 0", valid);
        end
        frame(PAL_LEN, PAL_LINES, 3, PAL_LEN / 2, -1);
        total++;
        if (valid !== 1'b1 || vmode !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_lock: valid=%b vmode=%b, required 1 00", valid, vmode);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++;
            $display("FAIL reset_mid_model: %0d cycles differ (first at %0d), required 0", cyc_diff, first_diff);
        end
        cyc_diff = 0;
    endtask

    task automatic test_random();
        int lines_tab[14] = '{249, 250, 280, 281, 299, 300, 330, 331, 479, 480, 520, 521, 313, 263};
        int len, nl, p0, e0;
        p0 = pulses;
        e0 = e_pulses;
        for (int k = 0; k < 4; k++) begin
            len = int'($urandom_range(2, 11));
            nl  = lines_tab[$urandom_range(0, 13)];
            frame(len, nl, int'($urandom_range(1, 3)), int'($urandom_range(0, len - 1)), -1);
        end
        total++;
        if (pulses - p0 !== e_pulses - e0) begin
            bad++;
            $display("FAIL random_vreset_count: got %0d, required %0d", pulses - p0, e_pulses - e0);
        end
        total++;
        if (cyc_diff !== 0) begin
            bad++;
            $display("FAIL random_model: %0d cycles differ (first at %0d), required 0", cyc_diff, first_diff);
        end
        cyc_diff = 0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cycles);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_pal();
        test_ntsc();
        test_mono();
        test_timeout();
        test_same_edge();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/st_video_analyzer.md
Name: st_video_analyzer

Overview:
- Receiving end of the ST shifter sync interface.
- Measures the hsync_n/vsync_n timing produced by the STE video core and classifies the frame as PAL 50 Hz, NTSC 60 Hz or mono 72 Hz.
- Produces the mode word (vmode) and a frame-aligned one-cycle sync pulse (vreset), which the HDMI encoder consumes to pick its output timing and re-align.
- Lets the HDMI path derive mode from the video it actually receives, not from the ntsc/mono_detect requests.

Parameters:
- MONO_LEN_MIN, 800, minimum clk32 cycles per line classed as a mono line
- MONO_LEN_MAX, 999, maximum clk32 cycles per line classed as a mono line
- COL_LEN_MIN, 1900, minimum clk32 cycles per line classed as a colour line
- COL_LEN_MAX, 2200, maximum clk32 cycles per line classed as a colour line
- STABLE_FRAMES, 2, consecutive identical classifications required before vmode changes (range 1..7)

Ports:
- clk32  in  1  32 MHz pixel clock; only clock
- reset  in  1  synchronous, active-high reset
- hsync_n  in  1  horizontal sync from video core, active low, clk32 domain
- vsync_n  in  1  vertical sync from video core, active low, clk32 domain
- vmode  out  2  00=PAL50, 01=NTSC60, 10=mono72, 11=never driven
- vreset  out  1  one-cycle frame-start pulse
- valid  out  1  last completed frame classified successfully
- line_len  out  12  clk32 cycles of last complete line, saturating
- frame_lines  out  10  lines in last complete frame, saturating

Behaviour:
- Reset (sync, active-high): vmode=00, vreset=0, valid=0, line_len=0, frame_lines=0; all internal counters, stability count and candidate=0; prior-sync registers=1.
- Reset mid-frame: every register returns to its reset value on the next clk32 edge; the first frame after reset is never classified.
- Edge detect: inputs are registered once. hs_fall = hs_q & ~hsync_n; vs_fall likewise. An edge is detected in the cycle the input goes low.
- Line counter lc (12b): increments every cycle, saturates at 4095. On hs_fall: line_len <= lc+1 (saturating), then lc <= 0.
- Frame line counter fc (10b): +1 on each hs_fall, saturates at 1023.
- On vs_fall: frame_lines <= fc; fc <= 0. If hs_fall occurs in the same cycle, fc <= 1 and the hs_fall counts for the new frame.
- The first vs_fall after reset only opens a frame; it does not classify.
- Classification at each later vs_fall, using fc before it is cleared and line_len as updated that cycle:
  - mono: line_len in [MONO_LEN_MIN, MONO_LEN_MAX] and fc in [480,520]
  - PAL: line_len in [COL_LEN_MIN, COL_LEN_MAX] and fc in [300,330]
  - NTSC: line_len in colour range and fc in [250,280]
  - anything else: invalid
- Stability (3b count):
  - valid classification equal to candidate: count increments, saturates at STABLE_FRAMES.
  - valid classification different from candidate: candidate <= new class, count <= 1.
  - When count reaches STABLE_FRAMES, vmode <= candidate and valid <= 1, registered the cycle after vs_fall.
  - Invalid classification: valid <= 0, count <= 0, vmode holds its last value.
- Timeout: if lc saturates at 4095 (hsync absent), valid <= 0 and count <= 0 in that cycle; vmode holds.
- vreset: arm on vs_fall; on the first hs_fall while armed, vreset=1 for exactly the next cycle and disarm.
  - hs_fall in the same cycle as vs_fall also fires.
  - A second vs_fall before any hs_fall just re-arms; one pulse only.
  - vreset is independent of valid.
- All outputs are registered. Latency from the qualifying input edge to output is 1 clk32.

Test Plan:
- PAL stream (line 2048 cycles, 313 lines, vsync low 3 lines) for 4 frames: line_len=2048, frame_lines=313; valid=1 and vmode=00 one cycle after the 3rd vs_fall after reset; exactly one vreset per frame, 1 cycle after the first hs_fall following vs_fall.
- Switch PAL to NTSC (2032 cycles, 263 lines): vmode stays 00 for one frame, becomes 01 after the second consecutive NTSC frame; valid stays 1.
- Mono (896 cycles, 501 lines): vmode=10. Then one corrupted frame of 400 lines: valid=0, vmode holds 10; the next two good frames restore valid=1.
- hsync held high for 5000 cycles: line_len saturates at 4095 and valid drops at lc saturation; restore PAL and require re-lock after STABLE_FRAMES frames.
- hs_fall and vs_fall in the same cycle: frame_lines unaffected for the closing frame, new frame counts start at 1, vreset fires the next cycle. Double vs_fall without hs_fall: single vreset.
- Assert reset for 1 cycle mid-frame: all outputs zero the next cycle; no classification at the first following vs_fall.
